// File: rtl/icache_assoc_fill.sv
// N-way set-associative instruction cache with its own miss-fill engine.
// Lookup is combinational in IDLE. A miss fetches one block as in-order word
// beats into a victim way, chosen as the lowest invalid way or the true-LRU way.
//
// state  | meaning
// IDLE   | serving lookups; a miss latches block address and victim
// FILL   | mem_req high, writing one word per mem_valid beat
// UPDATE | commit tag/valid/age for the filled line, apply pending flush
module icache_assoc_fill #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  output logic              if_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_valid,
  output logic [15:0]       miss_cnt
);

  localparam int OFF_W = $clog2(2 * WORDS);
  localparam int WRD_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, UPDATE} state_t;

  state_t state_q, state_d;

  logic             valid_q [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [AGE_W-1:0] age_q   [WAYS][SETS];
  logic [15:0]      data_q  [WAYS][SETS][WORDS];

  logic [AGE_W-1:0] victim_q, victim_next, vic_lru, vic_inv, hit_way, touch_way;
  logic [WRD_W-1:0] beat_q;
  logic             flush_pend_q;
  logic             hit, any_inv, miss_start, touch_en;
  logic [IDX_W-1:0] idx, fill_idx, touch_set;
  logic [TAG_W-1:0] tag, fill_tag;
  logic [WRD_W-1:0] word;
  logic             unused_bits;

  assign idx      = fetch_addr[OFF_W +: IDX_W];
  assign tag      = fetch_addr[ADDR_W-1 -: TAG_W];
  assign word     = fetch_addr[1 +: WRD_W];
  assign fill_idx = mem_addr[OFF_W +: IDX_W];
  assign fill_tag = mem_addr[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^{fetch_addr[0], mem_addr[OFF_W-1:0]};

  // Tag compare, hit word select and victim choice for the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_lru = '0;
    vic_inv = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[w][idx] == AGE_W'(WAYS - 1)) vic_lru = AGE_W'(w);
      if (!valid_q[w][idx]) begin
        any_inv = 1'b1;
        vic_inv = AGE_W'(w);
      end
    end
    victim_next = any_inv ? vic_inv : vic_lru;
    instr_valid = (state_q == IDLE) && fetch_en && !flush && hit;
    instr_out   = instr_valid ? data_q[hit_way][idx][word] : 16'h0000;
    if_stall    = fetch_en && !instr_valid;
    miss_start  = (state_q == IDLE) && fetch_en && !flush && !hit;
    touch_en    = instr_valid || (state_q == UPDATE);
    touch_way   = (state_q == UPDATE) ? victim_q : hit_way;
    touch_set   = (state_q == UPDATE) ? fill_idx : idx;
  end

  // Next-state logic; fill ends on the beat that lands in the last word.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    case (state_q)
      IDLE:   if (miss_start) state_d = FILL;
      FILL: begin
        mem_req = 1'b1;
        if (mem_valid && beat_q == WRD_W'(WORDS - 1)) state_d = UPDATE;
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Miss bookkeeping: block address, victim, beat counter, miss count, pending flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr     <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      miss_cnt     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (miss_start) begin
        mem_addr <= {tag, idx, {OFF_W{1'b0}}};
        victim_q <= victim_next;
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
      if (state_q == FILL && mem_valid)
        beat_q <= (beat_q == WRD_W'(WORDS - 1)) ? '0 : beat_q + 1'b1;
      if (state_q == UPDATE)                flush_pend_q <= 1'b0;
      else if (state_q == FILL && flush)    flush_pend_q <= 1'b1;
    end
  end

  // Line metadata: valid bits, tags and LRU ages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          tag_q[w][s]   <= '0;
          age_q[w][s]   <= AGE_W'(w);
        end
      end
    end else begin
      if (state_q == IDLE && flush) begin
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
      end else if (miss_start) begin
        valid_q[victim_next][idx] <= 1'b0;
      end
      if (state_q == UPDATE) begin
        tag_q[victim_q][fill_idx] <= fill_tag;
        if (flush_pend_q || flush) begin
          for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
        end else begin
          valid_q[victim_q][fill_idx] <= 1'b1;
        end
      end
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way)
            age_q[w][touch_set] <= '0;
          else if (age_q[w][touch_set] < age_q[touch_way][touch_set])
            age_q[w][touch_set] <= age_q[w][touch_set] + 1'b1;
        end
      end
    end
  end

  // Fill beats land in the victim way; data array needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_valid) data_q[victim_q][fill_idx][beat_q] <= mem_data;
  end

endmodule

// File: tb/tb_icache_assoc_fill.sv
module tb_icache_assoc_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic [15:0] mem_data = '0;
  logic        sel = 1'b0;

  logic [15:0] a_out, b_out, a_maddr, b_maddr, a_miss, b_miss;
  logic        a_valid, b_valid, a_stall, b_stall, a_req, b_req;
  logic [15:0] o_out, o_maddr, o_miss;
  logic        o_valid, o_stall, o_req;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_miss = '0;

  icache_assoc_fill #(.WAYS(2), .SETS(64), .WORDS(8), .ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr_out(a_out), .instr_valid(a_valid), .if_stall(a_stall), .flush(flush),
    .mem_req(a_req), .mem_addr(a_maddr), .mem_data(mem_data), .mem_valid(mem_valid),
    .miss_cnt(a_miss));

  icache_assoc_fill #(.WAYS(4), .SETS(32), .WORDS(4), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr_out(b_out), .instr_valid(b_valid), .if_stall(b_stall), .flush(flush),
    .mem_req(b_req), .mem_addr(b_maddr), .mem_data(mem_data), .mem_valid(mem_valid),
    .miss_cnt(b_miss));

  assign o_out   = sel ? b_out   : a_out;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_stall = sel ? b_stall : a_stall;
  assign o_req   = sel ? b_req   : a_req;
  assign o_maddr = sel ? b_maddr : a_maddr;
  assign o_miss  = sel ? b_miss  : a_miss;

  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    logic        en;
    logic [15:0] addr;
    logic        exp_valid;
    logic [15:0] exp_out;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    fetch_en = 1'b0;
    flush = 1'b0;
    mem_valid = 1'b0;
    fetch_addr = '0;
    @(negedge clk);
    chk("rst_req", o_req, 1'b0);
    chk("rst_maddr", o_maddr, 16'h0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_out", o_out, 16'h0);
    chk("rst_miss", o_miss, 16'h0);
    tick();
    rst = 1'b0;
    exp_miss = '0;
    tick();
  endtask

  // One miss + fill; gap idle cycles precede each beat; flush pulses during beat flush_beat.
  task automatic do_fill(input logic [15:0] addr, input logic [15:0] base, input logic exp_hit,
                         input int flush_beat, input int gap);
    int words;
    int wi;
    logic [15:0] blk;
    words = sel ? 4 : 8;
    blk = addr & ~16'(2 * words - 1);
    wi = int'((addr >> 1) & 16'(words - 1));
    fetch_en = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
    chk("miss_stall", o_stall, 1'b1);
    chk("miss_valid", o_valid, 1'b0);
    tick();
    if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
    for (int i = 0; i < words; i++) begin
      for (int g = 0; g < gap; g++) begin
        mem_valid = 1'b0;
        fetch_addr = addr ^ 16'h4000 ^ 16'(g * 2);
        @(negedge clk);
        chk("gap_req", o_req, 1'b1);
        chk("gap_maddr", o_maddr, blk);
        chk("gap_valid", o_valid, 1'b0);
        tick();
      end
      mem_valid = 1'b1;
      mem_data = base + 16'(i);
      flush = (i == flush_beat);
      @(negedge clk);
      chk("fill_req", o_req, 1'b1);
      chk("fill_maddr", o_maddr, blk);
      chk("fill_valid", o_valid, 1'b0);
      if (i == 0) chk("fill_miss_cnt", o_miss, exp_miss);
      tick();
    end
    mem_valid = 1'b0;
    flush = 1'b0;
    fetch_addr = addr;
    @(negedge clk);
    chk("upd_req", o_req, 1'b0);
    chk("upd_valid", o_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("done_valid", o_valid, exp_hit);
    chk("done_out", o_out, exp_hit ? base + 16'(wi) : 16'h0);
    chk("done_stall", o_stall, !exp_hit);
    fetch_en = 1'b0;
    tick();
  endtask

  // Single lookup that must hit.
  task automatic lookup(input logic [15:0] addr, input logic [15:0] exp_out);
    fetch_en = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
    chk("hit_valid", o_valid, 1'b1);
    chk("hit_out", o_out, exp_out);
    chk("hit_stall", o_stall, 1'b0);
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic flush_cycle(input logic [15:0] addr);
    fetch_en = 1'b1;
    fetch_addr = addr;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_out", o_out, 16'h0);
    tick();
    flush = 1'b0;
    fetch_en = 1'b0;
  endtask

  task automatic run_table(input int phase);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].phase == phase) begin
        fetch_en = vecs[i].en;
        fetch_addr = vecs[i].addr;
        @(negedge clk);
        chk("tbl_valid", o_valid, vecs[i].exp_valid);
        chk("tbl_out", o_out, vecs[i].exp_out);
        chk("tbl_stall", o_stall, vecs[i].exp_stall);
        chk("tbl_miss_cnt", o_miss, exp_miss);
        tick();
      end
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, 16'h1236, 1'b1, 16'h0003, 1'b0};
    vecs[1] = '{0, 1'b1, 16'h123E, 1'b1, 16'h0007, 1'b0};
    vecs[2] = '{0, 1'b1, 16'h1230, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{0, 1'b1, 16'h1234, 1'b1, 16'h0002, 1'b0};
    vecs[5] = '{1, 1'b1, 16'h1236, 1'b1, 16'h0003, 1'b0};
    vecs[6] = '{1, 1'b1, 16'h1232, 1'b1, 16'h0001, 1'b0};
    vecs[7] = '{1, 1'b1, 16'h1230, 1'b1, 16'h0000, 1'b0};
    vecs[8] = '{1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vecs[9] = '{1, 1'b1, 16'h1234, 1'b1, 16'h0002, 1'b0};

    // 2-way, 64 sets, 8 words
    sel = 1'b0;
    reset_dut();
    do_fill(16'h1234, 16'h0000, 1'b1, -1, 0);
    run_table(0);

    reset_dut();
    do_fill(16'h1234, 16'h0010, 1'b1, -1, 0);
    do_fill(16'h1A34, 16'h0020, 1'b1, -1, 0);
    lookup(16'h1234, 16'h0012);
    do_fill(16'h2A34, 16'h0050, 1'b1, -1, 0);
    lookup(16'h1234, 16'h0012);
    do_fill(16'h1A34, 16'h0020, 1'b1, -1, 0);

    reset_dut();
    do_fill(16'h1234, 16'h0060, 1'b1, -1, 2);
    lookup(16'h1234, 16'h0062);
    flush_cycle(16'h1234);
    do_fill(16'h1234, 16'h0070, 1'b1, -1, 0);
    flush_cycle(16'h0000);
    do_fill(16'h1234, 16'h0080, 1'b0, 3, 0);

    reset_dut();
    fetch_en = 1'b1;
    fetch_addr = 16'h1234;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_data = 16'h00A0 + 16'(i);
      tick();
    end
    mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req", o_req, 1'b0);
    chk("midrst_miss", o_miss, 16'h0);
    chk("midrst_valid", o_valid, 1'b0);
    tick();
    rst = 1'b0;
    exp_miss = '0;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      mem_data = 16'hDEAD;
      @(negedge clk);
      chk("stray_req", o_req, 1'b0);
      tick();
    end
    mem_valid = 1'b0;
    do_fill(16'h1234, 16'h0090, 1'b1, -1, 0);

    // 4-way, 32 sets, 4 words
    sel = 1'b1;
    reset_dut();
    do_fill(16'h1234, 16'h0000, 1'b1, -1, 0);
    run_table(1);

    reset_dut();
    do_fill(16'h1234, 16'h0010, 1'b1, -1, 0);
    do_fill(16'h1A34, 16'h0020, 1'b1, -1, 0);
    do_fill(16'h2A34, 16'h0030, 1'b1, -1, 0);
    do_fill(16'h3A34, 16'h0040, 1'b1, -1, 0);
    lookup(16'h1234, 16'h0012);
    do_fill(16'h4A34, 16'h0050, 1'b1, -1, 0);
    lookup(16'h1234, 16'h0012);
    lookup(16'h2A34, 16'h0032);
    do_fill(16'h1A34, 16'h0020, 1'b1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
